// File: rtl/spsram32_arbiter.sv
// Two-port arbiter in front of a single-port 32-bit SRAM: port A is a read-only
// instruction port, port B a read/write data port. Each transaction is issue + response.
module spsram32_arbiter #(
    parameter int unsigned RR = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a_adr,
    input  logic        a_stb,
    output logic        a_ack,
    output logic [31:0] a_rdat,
    input  logic [31:0] b_adr,
    input  logic [31:0] b_dat,
    input  logic [3:0]  b_sel,
    input  logic        b_we,
    input  logic        b_stb,
    output logic        b_ack,
    output logic [31:0] b_rdat,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        mem_en,
    output logic        mem_wr_en,
    output logic [3:0]  mem_wr_mask
);
    typedef enum logic [1:0] {IDLE, BUSY_A, BUSY_B} state_t;

    typedef struct packed {
        logic        en;
        logic        wr_en;
        logic [3:0]  mask;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    state_t   state, state_nx;
    logic     last_grant_b;
    logic     grant_a, grant_b;
    mem_req_t req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            last_grant_b <= 1'b1;
        end else begin
            state <= state_nx;
            if (grant_a)
                last_grant_b <= 1'b0;
            else if (grant_b)
                last_grant_b <= 1'b1;
        end
    end

    // Grant is combinational from stb in IDLE, so reset must mask it explicitly.
    always_comb begin
        state_nx = state;
        grant_a  = 1'b0;
        grant_b  = 1'b0;
        req      = '0;
        a_ack    = 1'b0;
        b_ack    = 1'b0;
        a_rdat   = '0;
        b_rdat   = '0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (a_stb && b_stb) begin
                        if (RR != 0) begin
                            grant_a = last_grant_b;
                            grant_b = ~last_grant_b;
                        end else begin
                            grant_b = 1'b1;
                        end
                    end else begin
                        grant_a = a_stb;
                        grant_b = b_stb;
                    end
                    if (grant_a) begin
                        state_nx = BUSY_A;
                        req.en   = 1'b1;
                        req.addr = a_adr;
                    end else if (grant_b) begin
                        state_nx  = BUSY_B;
                        req.en    = 1'b1;
                        req.addr  = b_adr;
                        req.wdata = b_dat;
                        req.wr_en = b_we;
                        req.mask  = b_we ? b_sel : 4'h0;
                    end
                end
                BUSY_A: begin
                    a_ack    = 1'b1;
                    a_rdat   = mem_rdata;
                    state_nx = IDLE;
                end
                BUSY_B: begin
                    b_ack    = 1'b1;
                    b_rdat   = mem_rdata;
                    state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    assign mem_en      = req.en;
    assign mem_wr_en   = req.wr_en;
    assign mem_wr_mask = req.mask;
    assign mem_addr    = req.addr;
    assign mem_wdata   = req.wdata;
endmodule

// File: tb/tb_spsram32_arbiter.sv
// Directed bench: a round-robin and a fixed-priority arbiter share the same requester
// stimulus, each driving its own SRAM model.
module tb_spsram32_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a_adr, b_adr, b_dat;
    logic [3:0]  b_sel;
    logic        a_stb, b_stb, b_we;

    logic        a_ack_rr, b_ack_rr, mem_en_rr, mem_wr_en_rr;
    logic [31:0] a_rdat_rr, b_rdat_rr, mem_addr_rr, mem_wdata_rr, mem_rdata_rr;
    logic [3:0]  mem_wr_mask_rr;
    logic        a_ack_fp, b_ack_fp, mem_en_fp, mem_wr_en_fp;
    logic [31:0] a_rdat_fp, b_rdat_fp, mem_addr_fp, mem_wdata_fp, mem_rdata_fp;
    logic [3:0]  mem_wr_mask_fp;

    logic [31:0] mem_rr [0:255];
    logic [31:0] mem_fp [0:255];

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    spsram32_arbiter #(.RR(1)) dut_rr (
        .clk(clk), .rst(rst),
        .a_adr(a_adr), .a_stb(a_stb), .a_ack(a_ack_rr), .a_rdat(a_rdat_rr),
        .b_adr(b_adr), .b_dat(b_dat), .b_sel(b_sel), .b_we(b_we), .b_stb(b_stb),
        .b_ack(b_ack_rr), .b_rdat(b_rdat_rr),
        .mem_addr(mem_addr_rr), .mem_wdata(mem_wdata_rr), .mem_rdata(mem_rdata_rr),
        .mem_en(mem_en_rr), .mem_wr_en(mem_wr_en_rr), .mem_wr_mask(mem_wr_mask_rr)
    );

    spsram32_arbiter #(.RR(0)) dut_fp (
        .clk(clk), .rst(rst),
        .a_adr(a_adr), .a_stb(a_stb), .a_ack(a_ack_fp), .a_rdat(a_rdat_fp),
        .b_adr(b_adr), .b_dat(b_dat), .b_sel(b_sel), .b_we(b_we), .b_stb(b_stb),
        .b_ack(b_ack_fp), .b_rdat(b_rdat_fp),
        .mem_addr(mem_addr_fp), .mem_wdata(mem_wdata_fp), .mem_rdata(mem_rdata_fp),
        .mem_en(mem_en_fp), .mem_wr_en(mem_wr_en_fp), .mem_wr_mask(mem_wr_mask_fp)
    );

    function automatic logic [31:0] init_word(input int i);
        logic [7:0] b;
        b = i[7:0];
        if (i == 'h10) return 32'hDEADBEEF;
        if (i == 'h04) return 32'hAABBCCDD;
        return {b, b, b, b};
    endfunction

    // SRAM models: read data one cycle after enable; contents reload while in reset.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem_rr[i] <= init_word(i);
        end else if (mem_en_rr) begin
            if (mem_wr_en_rr)
                for (int i = 0; i < 4; i++)
                    if (mem_wr_mask_rr[i]) mem_rr[mem_addr_rr[7:0]][8*i +: 8] <= mem_wdata_rr[8*i +: 8];
            mem_rdata_rr <= mem_rr[mem_addr_rr[7:0]];
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem_fp[i] <= init_word(i);
        end else if (mem_en_fp) begin
            if (mem_wr_en_fp)
                for (int i = 0; i < 4; i++)
                    if (mem_wr_mask_fp[i]) mem_fp[mem_addr_fp[7:0]][8*i +: 8] <= mem_wdata_fp[8*i +: 8];
            mem_rdata_fp <= mem_fp[mem_addr_fp[7:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; a_adr = 32'h10; b_adr = 32'h20; b_dat = '0; b_sel = '0; b_we = 1'b0;
        a_stb = 1'b1; b_stb = 1'b1;

        // reset holds everything quiet even with both stb high
        @(negedge clk); #1;
        chk("rst_mem_en_rr", 32'(mem_en_rr), 0);
        chk("rst_mem_en_fp", 32'(mem_en_fp), 0);
        chk("rst_acks_rr", {30'd0, a_ack_rr, b_ack_rr}, 0);
        chk("rst_wr_rr", {27'd0, mem_wr_en_rr, mem_wr_mask_rr}, 0);
        chk("rst_rdat_rr", a_rdat_rr | b_rdat_rr, 0);

        // both held from reset: RR gives A,B,A,B; fixed priority gives B every time
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) rst = 1'b0;
            #1;
            if (k % 2 == 0) begin
                chk($sformatf("rr_issue%0d_en", k), 32'(mem_en_rr), 1);
                chk($sformatf("rr_issue%0d_addr", k), mem_addr_rr, (k % 4 == 0) ? 32'h10 : 32'h20);
                chk($sformatf("fp_issue%0d_addr", k), mem_addr_fp, 32'h20);
            end else begin
                chk($sformatf("rr_ack%0d", k), {30'd0, a_ack_rr, b_ack_rr}, (k % 4 == 1) ? 2 : 1);
                chk($sformatf("rr_ack%0d_en", k), 32'(mem_en_rr), 0);
                chk($sformatf("fp_ack%0d", k), {30'd0, a_ack_fp, b_ack_fp}, 1);
                if (k == 1) begin
                    chk("rr_a_rdat", a_rdat_rr, 32'hDEADBEEF);
                    chk("fp_b_rdat", b_rdat_fp, 32'h20202020);
                end
            end
            chk($sformatf("rr_both_ack%0d", k), 32'(a_ack_rr & b_ack_rr), 0);
        end

        // B drops: fixed-priority finally serves A
        @(negedge clk); b_stb = 1'b0; #1;
        chk("fp_a_issue_addr", mem_addr_fp, 32'h10);
        chk("fp_a_issue_wr", {27'd0, mem_wr_en_fp, mem_wr_mask_fp}, 0);
        @(negedge clk); #1;
        chk("fp_a_ack", 32'(a_ack_fp), 1);
        chk("fp_a_rdat", a_rdat_fp, 32'hDEADBEEF);
        @(negedge clk); a_stb = 1'b0; #1;
        chk("idle_en", 32'(mem_en_rr), 0);
        chk("idle_addr_wdata", mem_addr_rr | mem_wdata_rr, 0);

        // masked B write; inputs scrambled during BUSY must not matter
        @(negedge clk);
        b_adr = 32'h4; b_dat = 32'h11223344; b_sel = 4'b0101; b_we = 1'b1; b_stb = 1'b1; #1;
        chk("wr_en", {27'd0, mem_en_rr, mem_wr_en_rr, 3'd0}, 32'h18);
        chk("wr_mask", 32'(mem_wr_mask_rr), 32'h5);
        chk("wr_addr", mem_addr_rr, 32'h4);
        chk("wr_wdata", mem_wdata_rr, 32'h11223344);
        @(negedge clk); b_adr = 32'h99; b_dat = 32'hFFFFFFFF; b_sel = 4'hF; #1;
        chk("wr_ack", {30'd0, a_ack_rr, b_ack_rr}, 1);
        chk("wr_busy_mem", {27'd0, mem_en_rr, mem_wr_en_rr, 3'd0}, 0);
        @(negedge clk); b_stb = 1'b0; b_we = 1'b0; #1;
        chk("b_rdat_noack", b_rdat_rr, 0);

        // read back through A, stb kept high past ack to re-issue back-to-back
        @(negedge clk); a_adr = 32'h4; a_stb = 1'b1; #1;
        chk("rd4_addr", mem_addr_rr, 32'h4);
        @(negedge clk); #1;
        chk("rd4_rdat_rr", a_rdat_rr, 32'hAA22CC44);
        chk("rd4_rdat_fp", a_rdat_fp, 32'hAA22CC44);
        @(negedge clk); #1;
        chk("reissue_en", 32'(mem_en_rr), 1);
        @(negedge clk); a_stb = 1'b0; #1;
        chk("reissue_ack", 32'(a_ack_rr), 1);

        // B read: no write strobes regardless of b_sel
        @(negedge clk); b_adr = 32'h10; b_sel = 4'hF; b_we = 1'b0; b_stb = 1'b1; #1;
        chk("brd_en_addr", {mem_addr_rr[30:0], mem_en_rr}, 32'h21);
        chk("brd_wr", {27'd0, mem_wr_en_rr, mem_wr_mask_rr}, 0);
        @(negedge clk); b_stb = 1'b0; #1;
        chk("brd_ack", {30'd0, a_ack_rr, b_ack_rr}, 1);
        chk("brd_rdat", b_rdat_rr, 32'hDEADBEEF);

        // reset in BUSY_A drops the ack; A is regranted after release
        @(negedge clk); a_adr = 32'h10; a_stb = 1'b1; #1;
        chk("rstb_issue", 32'(mem_en_rr), 1);
        @(negedge clk); rst = 1'b1; #1;
        chk("rstb_no_ack", {30'd0, a_ack_rr, mem_en_rr}, 0);
        chk("rstb_rdat", a_rdat_rr, 0);
        @(negedge clk); #1;
        chk("rstb_hold", {30'd0, a_ack_rr, mem_en_rr}, 0);
        @(negedge clk); rst = 1'b0; #1;
        chk("rstb_regrant", {mem_addr_rr[30:0], mem_en_rr}, 32'h21);
        @(negedge clk); a_stb = 1'b0; #1;
        chk("rstb_ack", 32'(a_ack_rr), 1);
        chk("rstb_rdat_ok", a_rdat_rr, 32'hDEADBEEF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/spsram32_arbiter.md
SPSRAM32_ARBITER -- requirements
Module: spsram32_arbiter

Interface
REQ-001 The block SHALL expose parameter RR, default 1: 1 = round-robin tie-break, 0 = fixed priority with port B winning ties.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high; ports clk, rst.
REQ-003 The block SHALL expose these ports (name, direction, width, meaning):
- clk  in  1  clock, all state on rising edge
- rst  in  1  async active-high reset
- a_adr  in  32  port A (read-only, instruction) word address
- a_stb  in  1  port A request, held until a_ack
- a_ack  out  1  port A one-cycle completion
- a_rdat  out  32  port A read data
- b_adr  in  32  port B (read/write, data) address
- b_dat  in  32  port B write data
- b_sel  in  4  port B byte-lane write mask
- b_we  in  1  port B write enable
- b_stb  in  1  port B request, held until b_ack
- b_ack  out  1  port B one-cycle completion
- b_rdat  out  32  port B read data
- mem_addr  out  32  SRAM address
- mem_wdata  out  32  SRAM write data
- mem_rdata  in  32  SRAM read data, valid the cycle after a read enable
- mem_en  out  1  SRAM enable
- mem_wr_en  out  1  SRAM write enable
- mem_wr_mask  out  4  SRAM byte mask

Function
REQ-004 The FSM SHALL have states IDLE, BUSY_A, BUSY_B; one transaction takes exactly 2 cycles (issue, response).
REQ-005 In IDLE with neither stb high, the block SHALL drive mem_en=0, mem_wr_en=0, mem_wr_mask=0, mem_addr=0, mem_wdata=0.
REQ-006 In IDLE with exactly one stb high, the block SHALL grant that port combinationally in the same cycle and transition to BUSY_x at the next edge.
REQ-007 In IDLE with both stb high and RR=1, the block SHALL grant the port not granted most recently; with RR=0, it SHALL grant B.
REQ-008 On an A grant, the block SHALL drive mem_en=1, mem_addr=a_adr, mem_wr_en=0, mem_wr_mask=0, mem_wdata=0.
REQ-009 On a B grant, the block SHALL drive mem_en=1, mem_addr=b_adr, mem_wdata=b_dat, mem_wr_en=b_we, and mem_wr_mask=b_sel when b_we=1 or 0 when b_we=0.
REQ-010 A register last_grant SHALL be updated on every grant, and SHALL reset to B so that A wins the first tie.
REQ-011 In BUSY_x, the block SHALL assert x_ack=1 for exactly one cycle, drive x_rdat=mem_rdata, drive all mem_* outputs to 0 with mem_en=0, ignore both stb inputs, and return to IDLE.
REQ-012 When x_ack=0, x_rdat SHALL be 32'h0; on a write ack, x_rdat SHALL carry mem_rdata, which requesters ignore.
REQ-013 Requester addresses and data SHALL be sampled only in the issue cycle; changes during BUSY have no effect.
REQ-014 A stb still high in the IDLE cycle after its ack SHALL be treated as a new request, giving a maximum throughput of one transaction per 2 cycles.
REQ-015 A losing requester SHALL be served at the next IDLE cycle under RR=1, so no port waits more than 2 transactions.
REQ-016 The block SHALL never assert a_ack and b_ack in the same cycle, and SHALL never assert mem_en in two consecutive cycles.

Reset
REQ-017 While rst=1, the block SHALL force state=IDLE, last_grant=B, a_ack=b_ack=0, a_rdat=b_rdat=0, mem_en=0, mem_wr_en=0, mem_wr_mask=0, regardless of stb.
REQ-018 If rst asserts in BUSY_x, the pending ack SHALL be dropped; after rst deasserts, the requester re-presents stb and receives a fresh grant.

Verification
REQ-019 The bench SHALL check: A read, a_adr=0x10, a_stb=1, MEM[0x10]=0xDEADBEEF -> cycle 0 mem_en=1, mem_addr=0x10; cycle 1 a_ack=1, a_rdat=0xDEADBEEF.
REQ-020 The bench SHALL check: B write, b_adr=0x4, b_dat=0x11223344, b_sel=4'b0101, b_we=1 -> mem_wr_en=1, mem_wr_mask=4'b0101; b_ack next cycle; a later read of 0x4 returns 0x??22??44, with the unwritten lanes unchanged.
REQ-021 The bench SHALL check: RR=1, both stb held high from reset for 4 transactions -> grant order A,B,A,B, acks on cycles 1,3,5,7, never both acks high together.
REQ-022 The bench SHALL check: RR=0, both stb held high -> B granted every transaction, A only after b_stb drops.
REQ-023 The bench SHALL check: rst pulsed during BUSY_A -> no a_ack, mem_en=0 during reset; after release, a_stb held high is granted in the first IDLE cycle and acked 1 cycle later.
REQ-024 The bench SHALL check: B read with b_we=0 and b_sel=4'hF -> mem_wr_mask=0, mem_wr_en=0, b_rdat=MEM contents on ack.
